// File: rtl/rip_regfile_mp.sv
// rip_regfile_mp: multi-port integer register file with write-through bypass
// and a write-pending scoreboard for the dual-issue pipeline.
`default_nettype none

module rip_regfile_mp #(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 32,
  parameter int              NR      = 2,
  parameter int              NW      = 1,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h8400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NW-1:0]         wen,
  input  logic [NW*$clog2(DEPTH)-1:0] wr_num,
  input  logic [NW*XLEN-1:0]    wdata,
  input  logic [NR-1:0]         ren,
  input  logic [NR*$clog2(DEPTH)-1:0] rs_num,
  output logic [NR*XLEN-1:0]    rs_data,
  output logic [NR-1:0]         rs_busy,
  input  logic                  iss_en,
  input  logic [$clog2(DEPTH)-1:0] iss_num,
  input  logic                  flush,
  output logic [DEPTH-1:0]      busy_vec
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_clr;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [XLEN-1:0]  w_rd_val  [NR];
  logic             w_rd_busy [NR];

  // Writeback resolves hazards first; flush then issue act on that result.
  always_comb begin
    w_busy_clr = r_busy;
    for (int k = 0; k < NW; k++) begin
      if (wen[k]) w_busy_clr[wr_num[k*AW +: AW]] = 1'b0;
    end
    w_busy_nxt = flush ? '0 : w_busy_clr;
    if (iss_en) w_busy_nxt[iss_num] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Ascending port scan lets the highest-indexed matching writer win the bypass.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      w_rd_val[i]  = r_regs[rs_num[i*AW +: AW]];
      w_rd_busy[i] = w_busy_clr[rs_num[i*AW +: AW]];
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && (wr_num[k*AW +: AW] == rs_num[i*AW +: AW]))
          w_rd_val[i] = wdata[k*XLEN +: XLEN];
      end
      if (rs_num[i*AW +: AW] == '0) begin
        w_rd_val[i]  = '0;
        w_rd_busy[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++)
        r_regs[j] <= (j == SP_IDX) ? SP_INIT : '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && (wr_num[k*AW +: AW] != '0))
          r_regs[wr_num[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      rs_data <= '0;
      rs_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      for (int i = 0; i < NR; i++) begin
        if (ren[i]) begin
          rs_data[i*XLEN +: XLEN] <= w_rd_val[i];
          rs_busy[i]              <= w_rd_busy[i];
        end
      end
    end
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rip_regfile_mp.sv
// tb_rip_regfile_mp: directed and randomized checks of rip_regfile_mp against
// an array-based reference model (NW=2 to exercise write-port priority).
`default_nettype none

module tb_rip_regfile_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NW-1:0]       wen;
  logic [NW*AW-1:0]    wr_num;
  logic [NW*XLEN-1:0]  wdata;
  logic [NR-1:0]       ren;
  logic [NR*AW-1:0]    rs_num;
  logic [NR*XLEN-1:0]  rs_data;
  logic [NR-1:0]       rs_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_num;
  logic                flush;
  logic [DEPTH-1:0]    busy_vec;

  int n_checks = 0;
  int n_err    = 0;

  rip_regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .SP_IDX(2), .SP_INIT(32'h8400)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wr_num(wr_num), .wdata(wdata),
    .ren(ren), .rs_num(rs_num), .rs_data(rs_data), .rs_busy(rs_busy),
    .iss_en(iss_en), .iss_num(iss_num), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural register array, busy set, and output latches.
  logic [XLEN-1:0]  m_regs [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic [XLEN-1:0]  m_rd [NR];
  logic             m_rb [NR];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) m_regs[j] = '0;
      m_regs[2] = 32'h8400;
      m_busy = '0;
      for (int i = 0; i < NR; i++) begin m_rd[i] = '0; m_rb[i] = 1'b0; end
    end else begin
      logic [DEPTH-1:0] after_wb;
      after_wb = m_busy;
      for (int k = 0; k < NW; k++)
        if (wen[k]) after_wb[wr_num[k*AW +: AW]] = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (ren[i]) begin
          int r;
          r = int'(rs_num[i*AW +: AW]);
          if (r == 0) begin
            m_rd[i] = '0; m_rb[i] = 1'b0;
          end else begin
            m_rd[i] = m_regs[r];
            for (int k = 0; k < NW; k++)
              if (wen[k] && int'(wr_num[k*AW +: AW]) == r) m_rd[i] = wdata[k*XLEN +: XLEN];
            m_rb[i] = after_wb[r];
          end
        end
      end
      for (int k = 0; k < NW; k++)
        if (wen[k] && wr_num[k*AW +: AW] != 0) m_regs[wr_num[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
      m_busy = flush ? '0 : after_wb;
      if (iss_en && iss_num != 0) m_busy[iss_num] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model rs_data", 64'(rs_data), 64'({m_rd[1], m_rd[0]}));
      chk("model rs_busy", 64'(rs_busy), 64'({m_rb[1], m_rb[0]}));
      chk("model busy_vec", 64'(busy_vec), 64'(m_busy));
    end
  end

  task automatic idle();
    wen = '0; wr_num = '0; wdata = '0; ren = '0; rs_num = '0;
    iss_en = 1'b0; iss_num = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset busy_vec", 64'(busy_vec), 64'h0);
    chk("reset rs_data", 64'(rs_data), 64'h0);
    chk("reset rs_busy", 64'(rs_busy), 64'h0);

    ren = 2'b11; rs_num = {5'd5, 5'd2};
    tick(); idle();
    chk("read x2 sp", 64'(rs_data[31:0]), 64'h8400);
    chk("read x5 zero", 64'(rs_data[63:32]), 64'h0);

    wen = 2'b01; wr_num[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
    tick(); idle();
    ren = 2'b01; rs_num[4:0] = 5'd5;
    tick(); idle();
    chk("read x5 written", 64'(rs_data[31:0]), 64'hDEADBEEF);
    wen = 2'b01; wr_num[4:0] = 5'd0; wdata[31:0] = 32'h1;
    tick(); idle();
    ren = 2'b01; rs_num[4:0] = 5'd0;
    tick(); idle();
    chk("read x0", 64'(rs_data[31:0]), 64'h0);

    wen = 2'b01; wr_num[4:0] = 5'd7; wdata[31:0] = 32'h12345678;
    ren = 2'b10; rs_num[9:5] = 5'd7;
    tick(); idle();
    chk("bypass port1", 64'(rs_data[63:32]), 64'h12345678);
    wen = 2'b11; wr_num = {5'd7, 5'd7}; wdata = {32'hB, 32'hA};
    ren = 2'b01; rs_num[4:0] = 5'd7;
    tick(); idle();
    chk("dual write bypass", 64'(rs_data[31:0]), 64'hB);
    ren = 2'b10; rs_num[9:5] = 5'd7;
    tick(); idle();
    chk("dual write stored", 64'(rs_data[63:32]), 64'hB);

    iss_en = 1'b1; iss_num = 5'd9;
    tick(); idle();
    chk("issue busy x9", 64'(busy_vec[9]), 64'h1);
    ren = 2'b01; rs_num[4:0] = 5'd9;
    tick(); idle();
    chk("rs_busy x9", 64'(rs_busy[0]), 64'h1);
    wen = 2'b01; wr_num[4:0] = 5'd9; wdata[31:0] = 32'h55;
    ren = 2'b01; rs_num[4:0] = 5'd9;
    tick(); idle();
    chk("wb clears rs_busy", 64'(rs_busy[0]), 64'h0);
    chk("wb bypass x9", 64'(rs_data[31:0]), 64'h55);
    chk("wb clears busy", 64'(busy_vec[9]), 64'h0);

    wen = 2'b01; wr_num[4:0] = 5'd9; iss_en = 1'b1; iss_num = 5'd9;
    tick(); idle();
    chk("issue beats wb", 64'(busy_vec[9]), 64'h1);
    iss_en = 1'b1; iss_num = 5'd3;
    tick(); idle();
    chk("busy x3 x9", 64'(busy_vec), 64'h208);
    flush = 1'b1; iss_en = 1'b1; iss_num = 5'd4;
    tick(); idle();
    chk("flush plus issue", 64'(busy_vec), 64'h10);
    iss_en = 1'b1; iss_num = 5'd0;
    tick(); idle();
    chk("issue x0 ignored", 64'(busy_vec), 64'h10);

    ren = 2'b01; rs_num[4:0] = 5'd5;
    tick(); idle();
    chk("hold pre", 64'(rs_data[31:0]), 64'hDEADBEEF);
    wen = 2'b01; wr_num[4:0] = 5'd5; wdata[31:0] = 32'h77;
    tick(); idle();
    chk("hold ren0 a", 64'(rs_data[31:0]), 64'hDEADBEEF);
    tick();
    chk("hold ren0 b", 64'(rs_data[31:0]), 64'hDEADBEEF);
    ren = 2'b01; rs_num[4:0] = 5'd5;
    tick(); idle();
    chk("hold release", 64'(rs_data[31:0]), 64'h77);

    // Asynchronous reset in the middle of a cycle, with state non-zero.
    #2 rst_n = 1'b0;
    #1;
    chk("async rs_data", 64'(rs_data), 64'h0);
    chk("async rs_busy", 64'(rs_busy), 64'h0);
    chk("async busy_vec", 64'(busy_vec), 64'h0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    ren = 2'b11; rs_num = {5'd5, 5'd2};
    tick(); idle();
    chk("post-reset x2", 64'(rs_data[31:0]), 64'h8400);
    chk("post-reset x5", 64'(rs_data[63:32]), 64'h0);

    for (int n = 0; n < 3000; n++) begin
      wen     = 2'($urandom);
      wr_num  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata   = {$urandom, $urandom};
      ren     = 2'($urandom);
      rs_num  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_en  = 1'($urandom);
      iss_num = 5'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 7) == 0);
      if ((n % 16) == 15) rs_num = {5'($urandom), 5'($urandom)};
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
